// File: rtl/nms_score_window.sv
`default_nettype none
// ============================================================================
// Module   : nms_score_window
// Purpose  : Builds the 3x3 corner-score neighbourhood plus centre pixel ahead
//            of the FAST non-maximum-suppression comparator.
//            Optional: NMS_BORDER_SUPPRESS_EN forces refScore to 0 on borders.
// Revision : 1.0 - initial release
// ============================================================================
module nms_score_window #(
    parameter int IMG_W = 180,
    parameter int IMG_H = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sof,
    input  logic [7:0]  in_pxl,
    input  logic [11:0] in_score,
    output logic        out_valid,
    output logic [7:0]  refPxl,
    output logic [11:0] refScore,
    output logic [11:0] nighScore0,
    output logic [11:0] nighScore1,
    output logic [11:0] nighScore2,
    output logic [11:0] nighScore3,
    output logic [11:0] nighScore4,
    output logic [11:0] nighScore5,
    output logic [11:0] nighScore6,
    output logic [11:0] nighScore7
);

    localparam int c_COL_W = $clog2(IMG_W);
    localparam int c_ROW_W = $clog2(IMG_H);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_COL_W-1:0] c_COL_ONE  = c_COL_W'(1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_ONE  = c_ROW_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_STREAM  = 3'd2,
        S_ROW_END = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    // One image column of the window: rows r-2, r-1, r and the centre-row pixel.
    typedef struct packed {
        logic [11:0] top;
        logic [11:0] mid;
        logic [11:0] bot;
        logic [7:0]  pix;
    } column_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [c_COL_W-1:0]   r_col;
    logic [c_COL_W-1:0]   w_colNext;
    logic [c_ROW_W-1:0]   r_row;
    logic [c_ROW_W-1:0]   w_rowNext;
    logic                 r_inReady;
    logic                 w_inReadyNext;

    logic                 w_accept;
    logic                 w_wrEn;
    logic                 w_shift;
    logic                 w_emit;
    logic                 w_maskTop;
    logic                 w_maskBot;
    logic                 w_maskLeft;
    logic                 w_maskRight;
    logic [c_COL_W-1:0]   w_rdAddr;

    logic [11:0]          r_lineA   [IMG_W];
    logic [11:0]          r_lineB   [IMG_W];
    logic [7:0]           r_linePix [IMG_W];
    logic [11:0]          w_rdA;
    logic [11:0]          w_rdB;
    logic [7:0]           w_rdPix;

    column_t              r_colL;
    column_t              r_colM;
    column_t              w_newCol;

    logic [11:0]          w_nigh [8];
    logic [11:0]          w_refScore;
    logic                 r_outValid;
    logic [7:0]           r_refPxl;
    logic [11:0]          r_refScore;
    logic [11:0]          r_nigh [8];

    assign w_accept = in_valid && r_inReady;
    assign w_wrEn   = w_accept && ((r_state != S_IDLE) || in_sof);
    assign w_shift  = w_wrEn || (r_state == S_ROW_END) || (r_state == S_DRAIN);

    // ------------------------------------------------------------------
    // Control: state, counters and window-emit decisions
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_inReady <= 1'b1;
        end else begin
            r_state   <= w_nextState;
            r_col     <= w_colNext;
            r_row     <= w_rowNext;
            r_inReady <= w_inReadyNext;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_colNext   = r_col;
        w_rowNext   = r_row;
        w_emit      = 1'b0;
        w_maskTop   = 1'b0;
        w_maskBot   = 1'b0;
        w_maskLeft  = 1'b0;
        w_maskRight = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && in_sof) begin
                    w_nextState = S_FILL;
                    w_colNext   = c_COL_ONE;
                    w_rowNext   = '0;
                end
            end
            S_FILL, S_STREAM: begin
                if (w_accept) begin
                    if (in_sof) begin
                        w_nextState = S_FILL;
                        w_colNext   = c_COL_ONE;
                        w_rowNext   = '0;
                    end else begin
                        if ((r_state == S_STREAM) && (r_col != '0)) begin
                            w_emit     = 1'b1;
                            w_maskTop  = (r_row == c_ROW_ONE);
                            w_maskLeft = (r_col == c_COL_ONE);
                        end
                        if (r_col == c_COL_LAST) begin
                            w_colNext = '0;
                            if (r_state == S_FILL) begin
                                w_nextState = S_STREAM;
                                w_rowNext   = r_row + c_ROW_ONE;
                            end else begin
                                w_nextState = S_ROW_END;
                            end
                        end else begin
                            w_colNext = r_col + c_COL_ONE;
                        end
                    end
                end
            end
            S_ROW_END: begin
                w_emit      = 1'b1;
                w_maskTop   = (r_row == c_ROW_ONE);
                w_maskRight = 1'b1;
                if (r_row == c_ROW_LAST) begin
                    w_nextState = S_DRAIN;
                end else begin
                    w_nextState = S_STREAM;
                    w_rowNext   = r_row + c_ROW_ONE;
                end
            end
            S_DRAIN: begin
                w_emit      = 1'b1;
                w_maskBot   = 1'b1;
                w_maskLeft  = (r_col == '0);
                w_maskRight = (r_col == c_COL_LAST);
                if (r_col == c_COL_LAST) begin
                    w_nextState = S_IDLE;
                    w_colNext   = '0;
                    w_rowNext   = '0;
                end else begin
                    w_colNext = r_col + c_COL_ONE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
        w_inReadyNext = (w_nextState == S_IDLE) || (w_nextState == S_FILL) ||
                        (w_nextState == S_STREAM);
    end

    // ------------------------------------------------------------------
    // Line buffers: lineA = previous score row, lineB = the row above it,
    // linePix = previous pixel row (the window's centre row).
    // ------------------------------------------------------------------
    always_comb begin
        case (r_state)
            S_ROW_END: w_rdAddr = '0;
            // Drain runs one column ahead of the centre it emits.
            S_DRAIN:   w_rdAddr = (r_col == c_COL_LAST) ? '0 : (r_col + c_COL_ONE);
            default:   w_rdAddr = in_sof ? '0 : r_col;
        endcase
    end

    assign w_rdA   = r_lineA[w_rdAddr];
    assign w_rdB   = r_lineB[w_rdAddr];
    assign w_rdPix = r_linePix[w_rdAddr];

    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_lineA[w_rdAddr]   <= in_score;
            r_lineB[w_rdAddr]   <= w_rdA;
            r_linePix[w_rdAddr] <= in_pxl;
        end
    end

    always_comb begin
        w_newCol.top = w_rdB;
        w_newCol.mid = w_rdA;
        w_newCol.bot = ((r_state == S_ROW_END) || (r_state == S_DRAIN)) ? 12'd0 : in_score;
        w_newCol.pix = w_rdPix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_colL <= '0;
            r_colM <= '0;
        end else if (w_shift) begin
            r_colL <= r_colM;
            r_colM <= w_newCol;
        end
    end

    // ------------------------------------------------------------------
    // Window assembly: left = r_colL, centre = r_colM, right = w_newCol
    // ------------------------------------------------------------------
    always_comb begin
        w_nigh[0] = (w_maskTop || w_maskLeft)  ? 12'd0 : r_colL.top;
        w_nigh[1] =  w_maskTop                 ? 12'd0 : r_colM.top;
        w_nigh[2] = (w_maskTop || w_maskRight) ? 12'd0 : w_newCol.top;
        w_nigh[3] =  w_maskLeft                ? 12'd0 : r_colL.mid;
        w_nigh[4] =  w_maskRight               ? 12'd0 : w_newCol.mid;
        w_nigh[5] = (w_maskBot || w_maskLeft)  ? 12'd0 : r_colL.bot;
        w_nigh[6] =  w_maskBot                 ? 12'd0 : r_colM.bot;
        w_nigh[7] = (w_maskBot || w_maskRight) ? 12'd0 : w_newCol.bot;
    end

`ifdef NMS_BORDER_SUPPRESS_EN
    // ROW_END and DRAIN centres always sit on the last column or last row.
    logic w_border;
    assign w_border   = (r_state != S_STREAM) || (r_row == c_ROW_ONE) || (r_col == c_COL_ONE);
    assign w_refScore = w_border ? 12'd0 : r_colM.mid;
`else
    assign w_refScore = r_colM.mid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_refPxl   <= '0;
            r_refScore <= '0;
            for (int i = 0; i < 8; i++) begin
                r_nigh[i] <= '0;
            end
        end else begin
            r_outValid <= w_emit;
            if (w_emit) begin
                r_refPxl   <= r_colM.pix;
                r_refScore <= w_refScore;
                for (int i = 0; i < 8; i++) begin
                    r_nigh[i] <= w_nigh[i];
                end
            end
        end
    end

    assign in_ready   = r_inReady;
    assign out_valid  = r_outValid;
    assign refPxl     = r_refPxl;
    assign refScore   = r_refScore;
    assign nighScore0 = r_nigh[0];
    assign nighScore1 = r_nigh[1];
    assign nighScore2 = r_nigh[2];
    assign nighScore3 = r_nigh[3];
    assign nighScore4 = r_nigh[4];
    assign nighScore5 = r_nigh[5];
    assign nighScore6 = r_nigh[6];
    assign nighScore7 = r_nigh[7];

endmodule
`default_nettype wire

// File: tb/tb_nms_score_window.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_nms_score_window
// Purpose  : Self-checking bench for nms_score_window on a 4x3 image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nms_score_window;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sof = 1'b0;
    logic [7:0]  in_pxl = '0;
    logic [11:0] in_score = '0;
    logic        out_valid;
    logic [7:0]  refPxl;
    logic [11:0] refScore;
    logic [11:0] nighScore0, nighScore1, nighScore2, nighScore3;
    logic [11:0] nighScore4, nighScore5, nighScore6, nighScore7;

    nms_score_window #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_pxl(in_pxl), .in_score(in_score),
        .out_valid(out_valid), .refPxl(refPxl), .refScore(refScore),
        .nighScore0(nighScore0), .nighScore1(nighScore1),
        .nighScore2(nighScore2), .nighScore3(nighScore3),
        .nighScore4(nighScore4), .nighScore5(nighScore5),
        .nighScore6(nighScore6), .nighScore7(nighScore7)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   fPix   [N];
    logic [11:0]  fScore [N];
    logic [115:0] expQ [$];
    logic [115:0] obsWin [N];
    int           nObs = 0;
    int           stallLog [N];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Reference: score at (r,c), zero outside the image.
    function automatic logic [11:0] sc(input int r, input int c);
        if (r < 0 || r >= H || c < 0 || c >= W) return 12'd0;
        return fScore[r * W + c];
    endfunction

    function automatic logic [115:0] expWin(input int r, input int c);
        logic [11:0] ctr;
        ctr = fScore[r * W + c];
`ifdef NMS_BORDER_SUPPRESS_EN
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) ctr = 12'd0;
`endif
        return {fPix[r * W + c], ctr,
                sc(r - 1, c - 1), sc(r - 1, c), sc(r - 1, c + 1),
                sc(r, c - 1), sc(r, c + 1),
                sc(r + 1, c - 1), sc(r + 1, c), sc(r + 1, c + 1)};
    endfunction

    task automatic fillFrame(input bit ramp);
        for (int i = 0; i < N; i++) begin
            fPix[i]   = 8'($urandom);
            fScore[i] = ramp ? 12'(i + 1) : 12'($urandom_range(0, 4095));
        end
    endtask

    task automatic loadExpected();
        expQ.delete();
        for (int i = 0; i < N; i++) expQ.push_back(expWin(i / W, i % W));
        nObs = 0;
    endtask

    // One clock; outputs sampled 1 ns after the edge.
    task automatic tick();
        logic bubble;
        logic [115:0] obs;
        bubble = !in_valid && in_ready && !rst;
        @(posedge clk);
        #1;
        if (out_valid) begin
            obs = {refPxl, refScore, nighScore0, nighScore1, nighScore2, nighScore3,
                   nighScore4, nighScore5, nighScore6, nighScore7};
            check("outAfterBubble", 128'(bubble), 128'd0);
            check("winAvail", 128'(expQ.size() > 0), 128'd1);
            if (expQ.size() > 0) begin
                check($sformatf("win%0d", nObs), 128'(obs), 128'(expQ.pop_front()));
            end
            if (nObs < N) obsWin[nObs] = obs;
            nObs++;
        end
    endtask

    task automatic sendBeat(input logic sof, input logic [7:0] p, input logic [11:0] s,
                            output int stalls);
        stalls   = 0;
        in_valid = 1'b1;
        in_sof   = sof;
        in_pxl   = p;
        in_score = s;
        while (!in_ready && stalls < 20) begin
            tick();
            stalls++;
        end
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // gapMode 0: valid held; 1: alternate bubble; 2: random bubbles
    task automatic sendFrame(input int gapMode);
        int st;
        for (int i = 0; i < N; i++) begin
            sendBeat(i == 0, fPix[i], fScore[i], st);
            stallLog[i] = st;
            if (gapMode == 1) tick();
            if (gapMode == 2) begin
                for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) tick();
            end
        end
    endtask

    task automatic waitReady(output int cnt);
        cnt = 0;
        while (!in_ready && cnt < 40) begin
            tick();
            cnt++;
        end
        for (int k = 0; k < 3; k++) tick();
    endtask

    task automatic endFrame(input string tag);
        check({tag, "_winCount"}, 128'(nObs), 128'(N));
        check({tag, "_queueEmpty"}, 128'(expQ.size()), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        int cnt;
        int nz;
        int others;
        logic [11:0] c00;
        logic [11:0] c23;
        logic [11:0] c12;

        // ---- reset ----
        rst = 1'b1;
        tick();
        tick();
        check("rst_inReady", 128'(in_ready), 128'd1);
        check("rst_outValid", 128'(out_valid), 128'd0);
        check("rst_refScore", 128'(refScore), 128'd0);
        check("rst_refPxl", 128'(refPxl), 128'd0);
        check("rst_nigh7", 128'(nighScore7), 128'd0);
        rst = 1'b0;
        tick();

        // ---- ramp frame, valid held high ----
        fillFrame(1'b1);
        loadExpected();
        sendFrame(0);
        waitReady(cnt);
        check("rowEndStall", 128'(stallLog[8]), 128'd1);
        others = 0;
        for (int i = 0; i < N; i++) if (i != 8) others += stallLog[i];
        check("otherStalls", 128'(others), 128'd0);
        check("drainLen", 128'(cnt), 128'd5);
        endFrame("ramp");

`ifdef NMS_BORDER_SUPPRESS_EN
        c00 = 12'd0; c23 = 12'd0; c12 = 12'd7;
`else
        c00 = 12'd1; c23 = 12'd12; c12 = 12'd7;
`endif
        check("win11", 128'(obsWin[5]),
              128'({fPix[5], 12'd6, 12'd1, 12'd2, 12'd3, 12'd5, 12'd7, 12'd9, 12'd10, 12'd11}));
        check("win00", 128'(obsWin[0]),
              128'({fPix[0], c00, 12'd0, 12'd0, 12'd0, 12'd0, 12'd2, 12'd0, 12'd5, 12'd6}));
        check("win23", 128'(obsWin[11]),
              128'({fPix[11], c23, 12'd7, 12'd8, 12'd0, 12'd11, 12'd0, 12'd0, 12'd0, 12'd0}));
        check("win12_ref", 128'(obsWin[6][107:96]), 128'(c12));
        nz = 0;
        for (int i = 0; i < N; i++) if (obsWin[i][107:96] != 12'd0) nz++;
`ifdef NMS_BORDER_SUPPRESS_EN
        check("nonzeroRef", 128'(nz), 128'd2);
`else
        check("nonzeroRef", 128'(nz), 128'd12);
`endif

        // ---- same frame with alternating bubbles ----
        loadExpected();
        sendFrame(1);
        waitReady(cnt);
        endFrame("toggle");

        // ---- sof abort: 5 beats of frame 1, then a full frame 2 ----
        fillFrame(1'b0);
        loadExpected();
        for (int i = 0; i < 5; i++) sendBeat(i == 0, 8'($urandom), 12'($urandom), st);
        sendFrame(0);
        waitReady(cnt);
        endFrame("abort");

        // ---- reset during STREAM, stray beats, then a clean frame ----
        expQ.delete();
        nObs = 0;
        for (int i = 0; i < 5; i++) sendBeat(i == 0, 8'($urandom), 12'($urandom), st);
        rst = 1'b1;
        tick();
        check("midRst_outValid", 128'(out_valid), 128'd0);
        check("midRst_inReady", 128'(in_ready), 128'd1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) sendBeat(1'b0, 8'($urandom), 12'($urandom), st);
        tick();
        check("straysDropped", 128'(nObs), 128'd0);
        fillFrame(1'b0);
        loadExpected();
        sendFrame(2);
        waitReady(cnt);
        endFrame("afterRst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
